// File: rtl/weight_loader.sv
// weight_loader: writes a flat weight/bias stream into the parameter memory in network topology order
//   clk, rst_n          clock and asynchronous active-low reset
//   load_start, abort   start a load (IDLE only) / cancel a load in progress
//   no_layers, n_in,
//   nl1..nl5            topology, validated and latched on load_start
//   s_data/s_valid/
//   s_ready             incoming word stream handshake
//   wr_*                registered memory write port, one cycle after each accepted word
//   busy, done, err     status: load running / load complete pulse / rejected config pulse
//   words_rx            words accepted in the current or last load
module weight_loader #(
  parameter int DW = 16,
  parameter int MAX_LAYERS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          abort,
  input  logic [5:0]    no_layers,
  input  logic [5:0]    n_in,
  input  logic [5:0]    nl1,
  input  logic [5:0]    nl2,
  input  logic [5:0]    nl3,
  input  logic [5:0]    nl4,
  input  logic [5:0]    nl5,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [2:0]    wr_layer,
  output logic [5:0]    wr_n,
  output logic [5:0]    wr_i,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [14:0]   words_rx
);
  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;
  state_t state;
  logic [5:0] nl_in [1:5];
  // cnt_q[0] holds n_in and cnt_q[L] the neuron count of layer L, so the fan-in of L is cnt_q[L-1]
  logic [5:0] cnt_q [8];
  logic [2:0] nol_q, lyr;
  logic [5:0] n, i, fanin;
  logic cfg_ok, xfer, last_i, last_n, last_l;
  assign nl_in = '{nl1, nl2, nl3, nl4, nl5};
  always_comb begin
    cfg_ok = no_layers != 6'd0 && no_layers <= 6'(MAX_LAYERS) && n_in != 6'd0;
    for (int k = 1; k <= 5; k++) cfg_ok = cfg_ok && (6'(k) > no_layers || nl_in[k] != 6'd0);
  end
  assign s_ready = state == WEIGHT || state == BIAS;
  assign busy    = s_ready;
  assign done    = state == DONE;
  assign xfer    = s_valid && s_ready;
  assign fanin   = cnt_q[lyr - 3'd1];
  assign last_i  = i == fanin - 6'd1;
  assign last_n  = n == cnt_q[lyr] - 6'd1;
  assign last_l  = lyr == nol_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      nol_q    <= '0;
      cnt_q    <= '{default: '0};
      lyr      <= '0;
      n        <= '0;
      i        <= '0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_layer <= '0;
      wr_n     <= '0;
      wr_i     <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      words_rx <= '0;
    end else begin
      wr_en <= xfer;
      err   <= 1'b0;
      if (xfer) begin
        wr_sel   <= state == BIAS;
        wr_layer <= lyr;
        wr_n     <= n;
        wr_i     <= state == BIAS ? 6'd0 : i;
        wr_data  <= s_data;
        words_rx <= words_rx + 15'(words_rx != '1);
      end
      case (state)
        IDLE: if (load_start && !abort) begin
          if (cfg_ok) begin
            state    <= WEIGHT;
            nol_q    <= 3'(no_layers);
            cnt_q    <= '{n_in, nl1, nl2, nl3, nl4, nl5, 6'd0, 6'd0};
            lyr      <= 3'd1;
            n        <= '0;
            i        <= '0;
            words_rx <= '0;
          end else err <= 1'b1;
        end
        WEIGHT: if (xfer) begin
          i <= i + 6'd1;
          if (last_i) state <= BIAS;
        end
        BIAS: if (xfer) begin
          i     <= '0;
          n     <= last_n ? 6'd0 : n + 6'd1;
          lyr   <= last_n && !last_l ? lyr + 3'd1 : lyr;
          state <= last_n && last_l ? DONE : WEIGHT;
        end
        default: state <= IDLE;
      endcase
      if (abort && s_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized self-checking bench comparing the write sequence against a topology model
module tb_weight_loader;
  logic clk, rst_n, load_start, abort, s_valid;
  logic [5:0] cfg_nol, cfg_nin;
  logic [5:0] cfg_nl [1:5];
  logic [15:0] s_data;
  logic s_ready, wr_en, wr_sel, busy, done, err;
  logic [2:0] wr_layer;
  logic [5:0] wr_n, wr_i;
  logic [15:0] wr_data;
  logic [14:0] words_rx;
  logic [51:0] outs;
  int checks = 0, errors = 0;
  int timing_bad = 0, done_bad = 0, done_cnt = 0, err_cnt = 0;
  bit pend = 0;
  int m_nol, m_nin;
  int m_nl [1:5];
  logic [15:0] data_q [$];
  logic [31:0] got_q [$], exp_q [$];

  weight_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
    .no_layers(cfg_nol), .n_in(cfg_nin),
    .nl1(cfg_nl[1]), .nl2(cfg_nl[2]), .nl3(cfg_nl[3]), .nl4(cfg_nl[4]), .nl5(cfg_nl[5]),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_layer(wr_layer), .wr_n(wr_n), .wr_i(wr_i),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .words_rx(words_rx)
  );

  assign outs = {s_ready, wr_en, wr_sel, wr_layer, wr_n, wr_i, wr_data, busy, done, err, words_rx};

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge rst_n) pend = 0;

  // Each write strobe must follow exactly one cycle after a handshake the bench observed
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en !== pend) timing_bad++;
      if (wr_en) got_q.push_back({wr_sel, wr_layer, wr_n, wr_i, wr_data});
      if (done) begin
        done_cnt++;
        if (!(wr_en && wr_sel) || busy || s_ready) done_bad++;
      end
      if (err) err_cnt++;
    end
    pend = rst_n && s_valid && s_ready;
  end

  // Expected writes: weights for every fan-in index then one bias, neuron by neuron, layer by layer,
  // paired with the words the stream actually delivered
  function automatic void build_exp();
    int k = 0;
    exp_q.delete();
    for (int l = 1; l <= m_nol; l++) begin
      int fan = (l == 1) ? m_nin : m_nl[l-1];
      for (int n = 0; n < m_nl[l]; n++)
        for (int i = 0; i <= fan; i++) begin
          if (k >= data_q.size()) return;
          exp_q.push_back({i == fan, 3'(l), 6'(n), i == fan ? 6'd0 : 6'(i), data_q[k]});
          k++;
        end
    end
  endfunction

  function automatic int first_diff();
    for (int k = 0; k < exp_q.size() || k < got_q.size(); k++)
      if (k >= exp_q.size() || k >= got_q.size() || got_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  function automatic int total_words();
    int t = 0;
    for (int l = 1; l <= m_nol; l++) t += m_nl[l] * (((l == 1) ? m_nin : m_nl[l-1]) + 1);
    return t;
  endfunction

  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  task automatic set_cfg(input int nol, nin, a, b, c, d, e);
    cfg_nol = 6'(nol); cfg_nin = 6'(nin);
    cfg_nl[1] = 6'(a); cfg_nl[2] = 6'(b); cfg_nl[3] = 6'(c); cfg_nl[4] = 6'(d); cfg_nl[5] = 6'(e);
  endtask

  task automatic clear();
    data_q.delete(); got_q.delete();
    timing_bad = 0; done_bad = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic start();
    m_nol = cfg_nol; m_nin = cfg_nin;
    for (int k = 1; k <= 5; k++) m_nl[k] = cfg_nl[k];
    load_start = 1; @(posedge clk); #1; load_start = 0;
  endtask

  task automatic stream(input int cnt, input int pct, input bit inc);
    int k = 0, cyc = 0;
    logic [15:0] w;
    w = inc ? 16'(data_q.size() + 1) : 16'($urandom);
    while (k < cnt && cyc < 20000) begin
      s_data = w;
      s_valid = $urandom_range(99) < pct;
      @(negedge clk);
      cyc++;
      if (s_valid && s_ready) begin
        data_q.push_back(w);
        k++;
        w = inc ? 16'(data_q.size() + 1) : 16'($urandom);
      end
      @(posedge clk); #1;
    end
    s_valid = 0;
    checks++;
    if (k < cnt) begin errors++; $display("FAIL stream_timeout: accepted %0d words, required %0d", k, cnt); end
  endtask

  task automatic check_writes(input string nm);
    int d;
    build_exp();
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL %s_writes: first diff at %0d got=%h exp=%h (got %0d writes, exp %0d)", nm, d,
               d < got_q.size() ? got_q[d] : 32'h0, d < exp_q.size() ? exp_q[d] : 32'h0, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 0; load_start = 0; abort = 0; s_valid = 0; s_data = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", outs); end
    @(posedge clk); #1; rst_n = 1;
    idle(1);
  endtask

  task automatic test_basic();
    clear(); set_cfg(2, 2, 3, 1, 0, 0, 0); start();
    stream(13, 100, 1);
    idle(3);
    check_writes("basic");
    checks++;
    if (got_q.size() != 13 || got_q[12] !== {1'b1, 3'd2, 6'd0, 6'd0, 16'd13}) begin
      errors++; $display("FAIL basic_last_bias: got %h, required %h", got_q.size() ? got_q[got_q.size()-1] : 32'h0, {1'b1, 3'd2, 6'd0, 6'd0, 16'd13});
    end
    checks++;
    if (got_q.size() < 9 || got_q[8] !== {1'b1, 3'd1, 6'd2, 6'd0, 16'd9}) begin
      errors++; $display("FAIL basic_l1_last_bias: got %h, required %h", got_q.size() >= 9 ? got_q[8] : 32'h0, {1'b1, 3'd1, 6'd2, 6'd0, 16'd9});
    end
    checks++;
    if (words_rx !== 15'd13) begin errors++; $display("FAIL basic_words_rx: got %0d, required 13", words_rx); end
    checks++;
    if (done_cnt != 1 || done_bad != 0) begin errors++; $display("FAIL basic_done: got %0d pulses (%0d misaligned), required 1 (0)", done_cnt, done_bad); end
    checks++;
    if (timing_bad != 0) begin errors++; $display("FAIL basic_timing: got %0d bad cycles, required 0", timing_bad); end
  endtask

  task automatic test_backpressure();
    clear(); set_cfg(2, 2, 3, 1, 0, 0, 0); start();
    // the latched configuration must be used, not whatever is on the pins now
    cfg_nol = 6'($urandom); cfg_nin = 6'($urandom);
    for (int k = 1; k <= 5; k++) cfg_nl[k] = 6'($urandom);
    stream(13, 45, 0);
    idle(3);
    check_writes("bp");
    checks++;
    if (words_rx !== 15'd13 || busy !== 1'b0) begin errors++; $display("FAIL bp_end: got words_rx=%0d busy=%b, required 13 0", words_rx, busy); end
    checks++;
    if (done_cnt != 1 || done_bad != 0 || timing_bad != 0) begin
      errors++; $display("FAIL bp_done_timing: got done=%0d bad=%0d timing=%0d, required 1 0 0", done_cnt, done_bad, timing_bad);
    end
  endtask

  task automatic test_random_cfgs();
    for (int r = 0; r < 4; r++) begin
      int nol, t;
      clear();
      nol = $urandom_range(1, 5);
      set_cfg(nol, $urandom_range(1, 8), 1, 1, 1, 1, 1);
      for (int k = 1; k <= 5; k++) cfg_nl[k] = k <= nol ? 6'($urandom_range(1, 8)) : 6'($urandom_range(0, 63));
      start();
      t = total_words();
      stream(t, 70, 0);
      idle(3);
      check_writes("rand");
      checks++;
      if (words_rx !== 15'(t) || done_cnt != 1 || done_bad != 0 || timing_bad != 0) begin
        errors++; $display("FAIL rand_end: got words_rx=%0d done=%0d bad=%0d timing=%0d, required %0d 1 0 0", words_rx, done_cnt, done_bad, timing_bad, t);
      end
    end
  endtask

  task automatic test_invalid();
    for (int c = 0; c < 3; c++) begin
      clear();
      if (c == 0) set_cfg(0, 2, 3, 1, 1, 1, 1);
      else if (c == 1) set_cfg(2, 2, 3, 0, 1, 1, 1);
      else set_cfg(6, 2, 3, 1, 1, 1, 1);
      s_valid = 1;
      start();
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
        errors++; $display("FAIL invalid%0d_err: got err=%b busy=%b ready=%b, required 1 0 0", c, err, busy, s_ready);
      end
      @(posedge clk); #1;
      idle(2);
      s_valid = 0;
      checks++;
      if (err_cnt != 1 || got_q.size() != 0 || busy !== 1'b0 || timing_bad != 0) begin
        errors++; $display("FAIL invalid%0d_quiet: got err pulses=%0d writes=%0d busy=%b, required 1 0 0", c, err_cnt, got_q.size(), busy);
      end
    end
  endtask

  task automatic test_busy_abort();
    logic [15:0] w;
    clear(); set_cfg(2, 2, 3, 1, 0, 0, 0); start();
    stream(2, 100, 0);
    load_start = 1; @(posedge clk); #1; load_start = 0;
    stream(3, 100, 0);
    abort = 1; @(posedge clk); #1; abort = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || words_rx !== 15'd5) begin
      errors++; $display("FAIL abort_state: got busy=%b ready=%b words_rx=%0d, required 0 0 5", busy, s_ready, words_rx);
    end
    @(posedge clk); #1;
    idle(2);
    check_writes("abort");
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt); end
    clear(); start();
    @(negedge clk);
    checks++;
    if (words_rx !== 15'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart_clear: got words_rx=%0d busy=%b, required 0 1", words_rx, busy); end
    @(posedge clk); #1;
    stream(3, 100, 0);
    w = 16'($urandom);
    s_data = w; s_valid = 1; abort = 1; data_q.push_back(w);
    @(posedge clk); #1; s_valid = 0; abort = 0;
    idle(2);
    check_writes("abort_xfer");
    checks++;
    if (words_rx !== 15'd4 || busy !== 1'b0 || timing_bad != 0) begin
      errors++; $display("FAIL abort_xfer_end: got words_rx=%0d busy=%b timing=%0d, required 4 0 0", words_rx, busy, timing_bad);
    end
    abort = 1; load_start = 1; @(posedge clk); #1; abort = 0; load_start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy=%b err=%b, required 0 0", busy, err); end
    @(posedge clk); #1;
    clear(); start();
    stream(13, 80, 0);
    idle(3);
    check_writes("restart");
    checks++;
    if (words_rx !== 15'd13 || done_cnt != 1) begin errors++; $display("FAIL restart_end: got words_rx=%0d done=%0d, required 13 1", words_rx, done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear(); set_cfg(2, 2, 3, 1, 0, 0, 0); start();
    stream(4, 100, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h, required 0", outs); end
    @(posedge clk); #1; rst_n = 1;
    idle(1);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got done=%0d busy=%b, required 0 0", done_cnt, busy); end
    clear(); start();
    stream(13, 100, 0);
    idle(3);
    check_writes("after_reset");
    checks++;
    if (words_rx !== 15'd13 || done_cnt != 1) begin errors++; $display("FAIL after_reset_end: got words_rx=%0d done=%0d, required 13 1", words_rx, done_cnt); end
  endtask

  task automatic test_max();
    clear(); set_cfg(1, 63, 63, 0, 0, 0, 0); start();
    stream(4032, 100, 0);
    idle(3);
    check_writes("max");
    checks++;
    if (got_q.size() != 4032 || got_q[4030] !== {1'b0, 3'd1, 6'd62, 6'd62, data_q[4030]} || got_q[4031] !== {1'b1, 3'd1, 6'd62, 6'd0, data_q[4031]}) begin
      errors++; $display("FAIL max_tail: got %0d writes, required 4032 ending in weight (1,62,62) and bias (1,62)", got_q.size());
    end
    checks++;
    if (words_rx !== 15'd4032 || done_cnt != 1 || timing_bad != 0) begin
      errors++; $display("FAIL max_end: got words_rx=%0d done=%0d timing=%0d, required 4032 1 0", words_rx, done_cnt, timing_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_cfgs();
    test_invalid();
    test_busy_abort();
    test_reset_mid();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Writer side of the parameter memory. The inference engine only reads weights and biases by (n, i) index; this block fills them.
- Accepts a flat 16-bit stream of weights and biases over a valid/ready handshake.
- Walks the network topology (layer, neuron, fan-in index) and issues indexed write strobes into the parameter memory.
- Sits between the host/DMA stream source and the parameter memory's write port. It runs before the inference engine is started.

Parameters:
- DW, 16, data word width (Q-format weight/bias word)
- MAX_LAYERS, 5, maximum supported layer count

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle request to begin loading; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done
- no_layers  in  6  number of layers to load (1..MAX_LAYERS)
- n_in  in  6  input feature count (fan-in of layer 1)
- nl1..nl5  in  6 each  neuron count of layers 1..5
- s_data  in  DW  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- wr_en  out  1  memory write strobe
- wr_sel  out  1  0 = weight, 1 = bias
- wr_layer  out  3  layer index, 1-based
- wr_n  out  6  neuron index within layer
- wr_i  out  6  fan-in index (weights only; 0 on bias writes)
- wr_data  out  DW  write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, config rejected
- words_rx  out  15  words accepted in current/last load

Behaviour:
- Reset: all outputs 0, state IDLE, words_rx = 0. Reset at any time, including mid-load, aborts immediately. No done is issued.
- Fan-in: layer 1 uses n_in; layer L>1 uses nl(L-1).
- Stream order: for L = 1..no_layers, for n = 0..nlL-1: fan-in weights with i = 0..fanin-1, then one bias.
- States: IDLE, WEIGHT, BIAS, DONE.
- IDLE: s_ready = 0. On load_start, config is validated and then handled as follows:
  - Valid: latch no_layers, n_in and nl1..nl5; clear counters and words_rx; go to WEIGHT; busy = 1 from the next cycle.
  - Invalid: pulse err for the next cycle and stay in IDLE. The config is invalid if no_layers = 0, no_layers > MAX_LAYERS, n_in = 0, or any nlL = 0 for L <= no_layers.
- WEIGHT/BIAS: s_ready = 1.
  - Transfer: s_valid and s_ready at a rising edge. No transfer means no counter change.
  - In WEIGHT, each transfer increments i. When i = fanin-1, go to BIAS.
  - In BIAS, a transfer resets i to 0 and increments n. When n = nlL-1, n resets to 0 and L increments. When L = no_layers, go to DONE; otherwise go to WEIGHT.
- Write latency: one cycle. A transfer at edge k drives wr_en = 1 in cycle k+1 with registered wr_sel, wr_layer, wr_n, wr_i and wr_data for that word. Otherwise wr_en = 0.
- Back-to-back transfers give back-to-back write strobes. Bubbles in s_valid are tolerated without loss.
- words_rx increments on every transfer. It saturates at 0x7FFF (unreachable with 6-bit sizes: max 5*63*64 = 20160).
- DONE: lasts exactly one cycle. done = 1, busy = 0 and s_ready = 0 in that cycle; this coincides with the wr_en of the final bias. Then return to IDLE.
- load_start while busy (WEIGHT/BIAS/DONE) is ignored. Config input changes during a load have no effect (latched copy is used).
- abort in WEIGHT/BIAS: go to IDLE next cycle and clear busy.
  - A transfer accepted in the same cycle as abort is still written; its wr_en follows one cycle later.
  - words_rx holds the count.
- Simultaneous abort and load_start in IDLE: abort wins and the start is ignored.
- nlL inputs for L > no_layers are don't-care.

Test Plan:
- Basic: no_layers=2, n_in=2, nl1=3, nl2=1; stream 13 words 0x0001..0x000D with continuous valid.
  - Layer 1 writes: (1,n0,w i0/i1, bias), (1,n1,…), (1,n2,…), i.e. words 1..9.
  - Layer 2 writes: (2,n0,w i0..i2) then bias = 0x000D.
  - done pulses with the final wr_en; words_rx=13.
- Backpressure gaps: same config, s_valid toggled pseudo-randomly -> identical write sequence and data, no duplicates or drops, wr_en only one cycle after each transfer.
- Invalid config: no_layers=0; separately no_layers=2 with nl2=0; separately no_layers=6 -> err pulse one cycle, busy stays 0, s_ready stays 0, no wr_en.
- Start while busy and abort: pulse load_start mid-load -> no restart. Assert abort after 5 transfers -> busy drops next cycle, words_rx=5, no done. A new load_start then restarts from layer 1 neuron 0 with words_rx cleared.
- Async reset mid-load: drop rst_n after 4 transfers -> all outputs 0 immediately. After release, a fresh load completes normally.
- Max size: no_layers=1, n_in=63, nl1=63 -> 4032 writes; last weight is (1,62,62), then bias (1,62); done fires; words_rx=4032.
